poly_op_sched: RTL and testbench

POLY_OP_SCHED -- requirements
Module: poly_op_sched

---
 rtl/poly_op_sched.sv | 97 +++++++++
 tb/tb_poly_op_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/poly_op_sched.sv
// rtl/poly_op_sched.sv - command FIFO feeding a one-at-a-time polynomial unit scheduler
module poly_op_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic [3:0] unit_start,
    input  logic [3:0] unit_done,
    output logic       busy,
    output logic [1:0] cur_op,
    output logic       all_done,
    output logic       err
);
    localparam int           AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  FULL     = (AW+1)'(DEPTH);
    // Timer value seen on the last allowed WAIT cycle (timer+1 reaches TIMEOUT-1).
    localparam logic [15:0]  TMO_LAST = 16'(TIMEOUT - 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [15:0]   timer;
    logic [1:0]    head;
    logic [3:0]    cur_mask, spurious;
    logic          push, pop, done_hit, tmo_hit, wait_exit;

    assign head      = mem[rd_ptr];
    assign cmd_ready = (count != FULL);
    assign push      = cmd_valid && cmd_ready && !rst;
    assign pop       = (state == S_ISSUE);
    assign cur_mask  = 4'b0001 << cur_op;
    assign done_hit  = (state == S_WAIT) && unit_done[cur_op];
    assign tmo_hit   = (state == S_WAIT) && !unit_done[cur_op] && (timer == TMO_LAST);
    assign wait_exit = done_hit || tmo_hit;
    assign spurious  = (state == S_WAIT) ? (unit_done & ~cur_mask) : unit_done;
    assign busy      = (state != S_IDLE) || (count != '0);
    // Gated by rst so a reset landing on an ISSUE cycle never starts a unit.
    assign unit_start = (pop && !rst) ? (4'b0001 << head) : 4'b0000;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= cmd_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= S_IDLE;
            timer    <= '0;
            cur_op   <= 2'b00;
            all_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            all_done <= wait_exit && (count == '0);
            err      <= err | (|spurious) | tmo_hit;

            case (state)
                S_IDLE: begin
                    if (count != '0)
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    cur_op <= head;
                    timer  <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (wait_exit)
                        state <= (count != '0) ? S_ISSUE : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_op_sched.sv
// tb/tb_poly_op_sched.sv - directed self-checking bench for poly_op_sched
module tb_poly_op_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic [3:0] unit_start;
    logic [3:0] unit_done;
    logic       busy;
    logic [1:0] cur_op;
    logic       all_done;
    logic       err;

    int total = 0;
    int bad   = 0;

    poly_op_sched #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .busy       (busy),
        .cur_op     (cur_op),
        .all_done   (all_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; unit_done = 4'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] seq [3];
        seq[0] = 2'd3; seq[1] = 2'd2; seq[2] = 2'd1;

        do_reset();
        chk("rst_ready",    cmd_ready,  1);
        chk("rst_busy",     busy,       0);
        chk("rst_err",      err,        0);
        chk("rst_start",    unit_start, 0);
        chk("rst_cur_op",   cur_op,     0);
        chk("rst_all_done", all_done,   0);

        // Single ADD: pushed at edge 0, done at edge 10
        cmd_valid = 1'b1; cmd_op = 2'd1; tick();
        cmd_valid = 1'b0;
        chk("single_c1_start", unit_start, 4'b0000);
        chk("single_c1_busy",  busy,       1);
        tick();
        chk("single_c2_start", unit_start, 4'b0010);
        tick();
        chk("single_c3_start", unit_start, 4'b0000);
        chk("single_cur_op",   cur_op,     1);
        repeat (7) tick();
        unit_done = 4'b0010; tick(); unit_done = 4'b0;
        chk("single_all_done", all_done, 1);
        chk("single_busy",     busy,     0);
        chk("single_err",      err,      0);
        tick();
        chk("single_all_done_clr", all_done, 0);

        // Full queue: one MULTIPLY running, then five more offered
        cmd_valid = 1'b1; cmd_op = 2'd0; tick();
        cmd_valid = 1'b0; tick();
        chk("full_first_start", unit_start, 4'b0001);
        tick();
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_ready_fill", cmd_ready, 1);
            tick();
        end
        chk("full_ready_low", cmd_ready, 0);
        tick(); tick();
        chk("full_ready_held", cmd_ready, 0);
        unit_done = 4'b0001; tick(); unit_done = 4'b0;
        chk("full_start_2",    unit_start, 4'b0001);
        chk("full_ready_issue", cmd_ready, 0);
        tick();
        chk("full_ready_after_pop", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("full_ready_refull", cmd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            unit_done = 4'b0001; tick(); unit_done = 4'b0;
            chk("full_start_next", unit_start, 4'b0001);
            chk("full_no_all_done", all_done,  0);
            tick();
            chk("full_start_clr", unit_start, 4'b0000);
        end
        unit_done = 4'b0001; tick(); unit_done = 4'b0;
        chk("full_all_done", all_done, 1);
        chk("full_busy",     busy,     0);
        chk("full_err",      err,      0);

        // Mixed order: 3, 2, 1 must start in push order
        cmd_valid = 1'b1;
        cmd_op = seq[0]; tick();
        cmd_op = seq[1]; tick();
        chk("order_start_0", unit_start, 4'b1000);
        cmd_op = seq[2]; tick();
        cmd_valid = 1'b0;
        chk("order_cur_0", cur_op, seq[0]);
        for (int i = 1; i < 3; i++) begin
            unit_done = 4'b0001 << seq[i-1]; tick(); unit_done = 4'b0;
            chk("order_start", unit_start, 4'b0001 << seq[i]);
            tick();
            chk("order_cur", cur_op, seq[i]);
        end
        unit_done = 4'b0010; tick(); unit_done = 4'b0;
        chk("order_all_done", all_done, 1);
        chk("order_err",      err,      0);

        // Timeout: SUBTRACT with no done
        cmd_valid = 1'b1; cmd_op = 2'd2; tick();
        cmd_valid = 1'b0; tick();
        chk("tmo_start", unit_start, 4'b0100);
        tick();
        for (int i = 1; i < 15; i++) begin
            chk("tmo_err_early", err, 0);
            tick();
        end
        chk("tmo_err_last_wait", err,  0);
        chk("tmo_busy_last",     busy, 1);
        tick();
        chk("tmo_err",      err,      1);
        chk("tmo_all_done", all_done, 1);
        chk("tmo_busy",     busy,     0);
        tick(); tick();
        chk("tmo_err_sticky", err, 1);

        // Spurious done while MULTIPLY runs
        do_reset();
        chk("spur_rst_err", err, 0);
        cmd_valid = 1'b1; cmd_op = 2'd0; tick();
        cmd_valid = 1'b0; tick(); tick();
        unit_done = 4'b0010; tick(); unit_done = 4'b0;
        chk("spur_err",   err,        1);
        chk("spur_busy",  busy,       1);
        chk("spur_start", unit_start, 4'b0000);
        unit_done = 4'b0001; tick(); unit_done = 4'b0;
        chk("spur_all_done", all_done, 1);

        // Done coinciding with the timeout cycle
        do_reset();
        cmd_valid = 1'b1; cmd_op = 2'd1; tick();
        cmd_valid = 1'b0; tick(); tick();
        repeat (14) tick();
        unit_done = 4'b0010; tick(); unit_done = 4'b0;
        chk("simul_err",      err,      0);
        chk("simul_all_done", all_done, 1);

        // Reset mid-operation with three queued commands
        cmd_valid = 1'b1; cmd_op = 2'd0; tick();
        cmd_valid = 1'b0; tick(); tick();
        cmd_valid = 1'b1;
        cmd_op = 2'd1; tick();
        cmd_op = 2'd2; tick();
        cmd_op = 2'd3; tick();
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1; tick();
        chk("midrst_start_rst", unit_start, 4'b0000);
        tick();
        rst = 1'b0; cmd_valid = 1'b0;
        chk("midrst_busy",  busy,      0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_err",   err,       0);
        chk("midrst_cur",   cur_op,    0);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_start", unit_start, 4'b0000);
            tick();
        end
        chk("midrst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
